// File: rtl/alu_logic_arbiter.sv
// alu_logic_arbiter: two valid/ready requesters share one AND/OR/NOT/XOR unit.
// The unit is granted round-robin and each result is returned with its requester id.
module alu_logic_arbiter #(
    parameter int bits = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_op,
    input  logic [bits-1:0] req0_a,
    input  logic [bits-1:0] req0_b,
    input  logic            req0_fin,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_op,
    input  logic [bits-1:0] req1_a,
    input  logic [bits-1:0] req1_b,
    input  logic            req1_fin,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [bits-1:0] rsp_out,
    output logic            rsp_N,
    output logic            rsp_Z,
    output logic            rsp_V,
    output logic            rsp_C
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          r_state, w_next;
    logic            r_last_grant, r_fin, r_valid, r_rsp_id, r_n, r_z;
    logic [1:0]      r_op;
    logic [bits-1:0] r_a, r_b, r_out, w_res;
    logic            w_gnt_id, w_hs;

    // Contention goes to whoever was not served last; otherwise the lone valid requester wins.
    assign w_gnt_id = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign w_hs     = req0_ready || req1_ready;
    assign w_res    = (r_op == 2'b00) ? (r_a & r_b) :
                      (r_op == 2'b01) ? (r_a | r_b) :
                      (r_op == 2'b10) ? ~(r_fin ? r_b : r_a) : (r_a ^ r_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (r_state == IDLE) begin
            req0_ready = req0_valid && !w_gnt_id;
            req1_ready = req1_valid && w_gnt_id;
            w_next     = (req0_valid || req1_valid) ? EXEC : IDLE;
        end else if (r_state == EXEC) begin
            w_next = RESP;
        end else begin
            w_next = rsp_ready ? IDLE : RESP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_fin        <= 1'b0;
            r_valid      <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_out        <= '0;
            r_n          <= 1'b0;
            r_z          <= 1'b0;
        end else begin
            if (w_hs) begin
                r_last_grant <= w_gnt_id;
                r_op         <= w_gnt_id ? req1_op  : req0_op;
                r_a          <= w_gnt_id ? req1_a   : req0_a;
                r_b          <= w_gnt_id ? req1_b   : req0_b;
                r_fin        <= w_gnt_id ? req1_fin : req0_fin;
            end
            if (r_state == EXEC) begin
                r_out    <= w_res;
                r_n      <= w_res[bits-1];
                r_z      <= (w_res == '0);
                r_valid  <= 1'b1;
                r_rsp_id <= r_last_grant;
            end else if (r_state == RESP && rsp_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_out   = r_out;
    assign rsp_N     = r_n;
    assign rsp_Z     = r_z;
    assign rsp_V     = 1'b0;
    assign rsp_C     = 1'b0;
endmodule

// File: tb/tb_alu_logic_arbiter.sv
// tb_alu_logic_arbiter: directed vectors for arbitration, handshake timing and the logic functions.
// Observed word layout: {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_out[3:0], N, Z, V, C}.
module tb_alu_logic_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req0_ready, req0_fin = 1'b0;
    logic       req1_valid = 1'b0, req1_ready, req1_fin = 1'b0;
    logic [1:0] req0_op = '0, req1_op = '0;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_id;
    logic [3:0] rsp_out;
    logic       rsp_N, rsp_Z, rsp_V, rsp_C;
    logic [11:0] obs, exp;
    int vectors = 0, miscompares = 0;

    alu_logic_arbiter #(.bits(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_fin(req0_fin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_fin(req1_fin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_N(rsp_N), .rsp_Z(rsp_Z), .rsp_V(rsp_V), .rsp_C(rsp_C)
    );

    always #5 clk = ~clk;

    assign obs = {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_out, rsp_N, rsp_Z, rsp_V, rsp_C};

    task automatic do_reset();
        rst_n = 1'b0;
        {req0_valid, req1_valid, req0_fin, req1_fin, rsp_ready} = '0;
        {req0_op, req1_op, req0_a, req0_b, req1_a, req1_b} = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {req0_valid, req1_valid, rsp_ready} = '0;
        #1;
        exp = 12'h000; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL reset_low obs=%b exp=%b", obs, exp); end
        do_reset();
        @(negedge clk); #1;
        exp = 12'h000; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL reset_idle obs=%b exp=%b", obs, exp); end
    endtask

    task automatic test_and();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'b1100; req0_b = 4'b1010; #1;
        exp = {2'b10, 1'b0, 1'b0, 4'h0, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL and_grant obs=%b exp=%b", obs, exp); end
        @(negedge clk); req0_valid = 1'b0; #1;
        exp = {2'b00, 1'b0, 1'b0, 4'h0, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL and_exec obs=%b exp=%b", obs, exp); end
        @(negedge clk); #1;
        exp = {2'b00, 1'b1, 1'b0, 4'b1000, 4'b1000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL and_resp obs=%b exp=%b", obs, exp); end
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0; #1;
        exp = {2'b00, 1'b0, 1'b0, 4'b1000, 4'b1000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL and_retire obs=%b exp=%b", obs, exp); end
    endtask

    task automatic test_round_robin();
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b11; req0_a = 4'hF; req0_b = 4'hF;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 4'h3; req1_b = 4'h4; #1;
        exp = {2'b10, 1'b0, 1'b0, 4'h0, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rr_grant0 obs=%b exp=%b", obs, exp); end
        @(negedge clk); #1;
        exp = {2'b00, 1'b0, 1'b0, 4'h0, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rr_exec0 obs=%b exp=%b", obs, exp); end
        @(negedge clk); #1;
        exp = {2'b00, 1'b1, 1'b0, 4'h0, 4'b0100}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rr_resp0 obs=%b exp=%b", obs, exp); end
        @(negedge clk); #1;
        exp = {2'b01, 1'b0, 1'b0, 4'h0, 4'b0100}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rr_grant1 obs=%b exp=%b", obs, exp); end
        repeat (2) @(negedge clk); #1;
        exp = {2'b00, 1'b1, 1'b1, 4'h7, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rr_resp1 obs=%b exp=%b", obs, exp); end
        @(negedge clk); #1;
        exp = {2'b10, 1'b0, 1'b1, 4'h7, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rr_grant2 obs=%b exp=%b", obs, exp); end
    endtask

    task automatic test_not();
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b1;
        req1_valid = 1'b1; req1_op = 2'b10; req1_fin = 1'b1; req1_a = 4'h0; req1_b = 4'h5; #1;
        exp = {2'b01, 1'b0, 1'b0, 4'h0, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL not_grant obs=%b exp=%b", obs, exp); end
        @(negedge clk); req1_fin = 1'b0;
        @(negedge clk); #1;
        exp = {2'b00, 1'b1, 1'b1, 4'hA, 4'b1000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL not_b obs=%b exp=%b", obs, exp); end
        @(negedge clk); #1;
        exp = {2'b01, 1'b0, 1'b1, 4'hA, 4'b1000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL not_regrant obs=%b exp=%b", obs, exp); end
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk); #1;
        exp = {2'b00, 1'b1, 1'b1, 4'hF, 4'b1000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL not_a obs=%b exp=%b", obs, exp); end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 4'h5; req1_b = 4'hA; #1;
        exp = {2'b01, 1'b0, 1'b0, 4'h0, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL bp_grant1 obs=%b exp=%b", obs, exp); end
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'hC; req0_b = 4'hA; #1;
        exp = {2'b00, 1'b0, 1'b0, 4'h0, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL bp_exec obs=%b exp=%b", obs, exp); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            exp = {2'b00, 1'b1, 1'b1, 4'hF, 4'b1000}; vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL bp_hold%0d obs=%b exp=%b", i, obs, exp); end
        end
        @(negedge clk); rsp_ready = 1'b1; #1;
        exp = {2'b00, 1'b1, 1'b1, 4'hF, 4'b1000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL bp_release obs=%b exp=%b", obs, exp); end
        @(negedge clk); #1;
        exp = {2'b10, 1'b0, 1'b1, 4'hF, 4'b1000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL bp_grant0 obs=%b exp=%b", obs, exp); end
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk); #1;
        exp = {2'b00, 1'b1, 1'b0, 4'h8, 4'b1000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL bp_resp0 obs=%b exp=%b", obs, exp); end
    endtask

    task automatic test_capture();
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b11; req0_a = 4'h6; req0_b = 4'h3; #1;
        exp = {2'b10, 1'b0, 1'b0, 4'h0, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL cap_grant obs=%b exp=%b", obs, exp); end
        @(negedge clk);
        req0_valid = 1'b0; req0_op = 2'b00; req0_a = 4'hF; req0_b = 4'hF;
        @(negedge clk); #1;
        exp = {2'b00, 1'b1, 1'b0, 4'h5, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL cap_resp obs=%b exp=%b", obs, exp); end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 4'h8; req0_b = 4'h1; #1;
        exp = {2'b10, 1'b0, 1'b0, 4'h0, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL ar_grant obs=%b exp=%b", obs, exp); end
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk); #1;
        exp = {2'b00, 1'b1, 1'b0, 4'h9, 4'b1000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL ar_resp obs=%b exp=%b", obs, exp); end
        #1 rst_n = 1'b0; #1;
        exp = 12'h000; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL ar_cleared obs=%b exp=%b", obs, exp); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_op = 2'b00; req1_a = 4'hF; req1_b = 4'hF;
        @(negedge clk); rst_n = 1'b1; #1;
        exp = {2'b10, 1'b0, 1'b0, 4'h0, 4'b0000}; vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL ar_prio0 obs=%b exp=%b", obs, exp); end
        @(negedge clk); {req0_valid, req1_valid} = '0;
    endtask

    initial begin
        test_reset();
        test_and();
        test_round_robin();
        test_not();
        test_backpressure();
        test_capture();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_logic_arbiter.md
Name: alu_logic_arbiter

Overview:
- Shares one 4-function logic unit (AND, OR, NOT, XOR) between two requesters.
- Each requester issues operations over a valid/ready handshake.
- A round-robin arbiter grants one request at a time; a 3-state FSM captures operands, executes, and holds a tagged response until it is consumed.
- Sits between the control path and the combinational logic datapath. Produces the result plus N/Z/V/C flags.

Parameters:
- bits, 4, operand/result width (≥2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_op  input  2  00 AND, 01 OR, 10 NOT, 11 XOR
- req0_a  input  bits  operand A
- req0_b  input  bits  operand B
- req0_fin  input  1  NOT source select: 0 = A, 1 = B; ignored for other ops
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_fin  same as requester 0, for requester 1
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the response
- rsp_out  output  bits  result
- rsp_N  output  1  rsp_out[bits-1]
- rsp_Z  output  1  rsp_out == 0
- rsp_V  output  1  always 0
- rsp_C  output  1  always 0

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n). All registers clear immediately on rst_n low.
- Reset values:
  - FSM = IDLE
  - rsp_valid = 0
  - rsp_id = 0
  - rsp_out = 0, and N = Z = V = C = 0 (Z registered, not derived from the reset value)
  - round-robin pointer last_grant = 1, so requester 0 wins first
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready is combinational and asserted only for the arbiter winner, and only when the winner is valid.
  - Winner when only one requester is valid: that requester.
  - Winner when both are valid: the requester that is not last_grant.
  - On handshake (valid & ready): latch op, a, b, fin and id; set last_grant = id; go to EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - Both readys = 0.
  - Compute result from the latched operands:
    - AND: a & b
    - OR: a | b
    - NOT: ~a if fin = 0, ~b if fin = 1
    - XOR: a ^ b
  - Register rsp_out and flags, set rsp_valid = 1, go to RESP.
- RESP:
  - Both readys = 0.
  - rsp_* outputs stay stable while rsp_valid & !rsp_ready.
  - On rsp_ready: clear rsp_valid, go to IDLE. rsp_out/flags keep their last value (don't-care).
- Latency: request handshake in cycle T → rsp_valid high in cycle T+2. Minimum issue interval is 3 cycles.
- No new request is accepted in the same cycle a response retires. A new handshake is possible the cycle after returning to IDLE.
- A requester's valid must stay high until it sees ready. The arbiter must not drop or reorder a waiting request.
- Starvation-free: with both requesters continuously valid, grants alternate 0, 1, 0, 1, …
- Operands are captured at the handshake. Input changes after it do not affect the result.
- rst_n asserted in EXEC or RESP:
  - The in-flight op is discarded and rsp_valid drops immediately.
  - After release, requester 0 has priority.
- Unknown op codes cannot occur (2-bit field fully decoded).

Test Plan:
- Reset, then req0 AND, a=4'b1100, b=4'b1010 → req0_ready in T, rsp_valid in T+2 with out=4'b1000, N=1, Z=0, V=0, C=0, id=0.
- Both valid from reset: req0 XOR 4'hF/4'hF, req1 OR 4'h3/4'h4 → first response id=0, out=0, Z=1. Second response id=1, out=4'h7, N=0. Third grant (both still valid) goes to req0.
- req1 NOT with fin=1, a=4'h0, b=4'h5 → out=4'hA, N=1, id=1. Repeat with fin=0 → out=4'hF.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → outputs stable, both readys=0, req0 still waiting. rsp_ready=1 → IDLE next cycle, req0 granted the following cycle.
- Change req0_a/b in the cycle after the handshake → the result reflects the captured values.
- Assert rst_n=0 asynchronously mid-RESP → rsp_valid=0 within the same cycle, all outputs 0. After release, with both valid, req0 is granted first.
